tdp_ram36k_port_arbiter: RTL and testbench

Shares port A of one TDP_RAM36K between two independent requesters, using round-robin arbitration with a combinational grant. It also contains a clear engine that zero-fills the whole memory on command. The block sits between the requester logic and the RAM primitive, drives every port-A pin of the primitive, and returns read data tagged to the requester that issued the read. Port B of the primitive is not controlled by this block.

---
 rtl/tdp_ram36k_port_arbiter_if.sv | 28 ++
 rtl/tdp_ram36k_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_tdp_ram36k_port_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tdp_ram36k_port_arbiter_if.sv
// Requester-side bundle for the port-A arbiter: two request channels,
// their grants and read returns, and the clear-engine handshake.
`timescale 1ns/1ps
interface tdp_ram36k_port_arbiter_if #(
   parameter int DEPTH_LOG2 = 10
);
   logic                  req0, req1;
   logic                  we0, we1;
   logic [DEPTH_LOG2-1:0] addr0, addr1;
   logic [35:0]           wdata0, wdata1;
   logic [3:0]            be0, be1;
   logic                  gnt0, gnt1;
   logic                  rvalid0, rvalid1;
   logic [35:0]           rdata;
   logic                  clr_start;
   logic                  clr_busy;
   logic                  clr_done;

   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, be0, be1, clr_start,
      input  gnt0, gnt1, rvalid0, rvalid1, rdata, clr_busy, clr_done
   );

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, be0, be1, clr_start,
      output gnt0, gnt1, rvalid0, rvalid1, rdata, clr_busy, clr_done
   );
endinterface

// File: rtl/tdp_ram36k_port_arbiter.sv
// Round-robin sharing of TDP_RAM36K port A between two requesters, with a
// zero-fill clear engine and a tagged read-return pipeline.
`timescale 1ns/1ps
module tdp_ram36k_port_arbiter #(
   parameter int DEPTH_LOG2 = 10,
   parameter int CLR_WORDS  = 1 << DEPTH_LOG2
) (
   input  logic                       CLK,
   input  logic                       RESET,
   tdp_ram36k_port_arbiter_if.slave   bus,
   output logic                       ram_wen,
   output logic                       ram_ren,
   output logic [3:0]                 ram_be,
   output logic [14:0]                ram_addr,
   output logic [31:0]                ram_wdata,
   output logic [3:0]                 ram_wparity,
   input  logic [31:0]                ram_rdata,
   input  logic [3:0]                 ram_rparity
);
   typedef enum logic {IDLE, CLEAR} state_t;

   localparam logic [DEPTH_LOG2-1:0] LAST_WORD = DEPTH_LOG2'(CLR_WORDS - 1);

   state_t                state_q, state_d;
   logic [DEPTH_LOG2-1:0] cnt_q, cnt_d;
   logic                  last_q, last_d;
   logic                  wen_q, wen_d;
   logic                  ren_q, ren_d;
   logic [3:0]            be_q, be_d;
   logic [DEPTH_LOG2-1:0] addr_q, addr_d;
   logic [35:0]           wdata_q, wdata_d;
   logic                  rid_q, rid_d;
   logic                  done_q, done_d;
   logic                  p1_valid_q, p1_valid_d;
   logic                  p1_id_q, p1_id_d;
   logic                  p2_valid_q, p2_valid_d;
   logic                  p2_id_q, p2_id_d;
   logic                  gnt0, gnt1;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      last_d     = last_q;
      wen_d      = 1'b0;
      ren_d      = 1'b0;
      be_d       = be_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rid_d      = rid_q;
      done_d     = 1'b0;
      gnt0       = 1'b0;
      gnt1       = 1'b0;
      // The read tag travels alongside ren so it lines up with RAM latency.
      p1_valid_d = ren_q;
      p1_id_d    = rid_q;
      p2_valid_d = p1_valid_q;
      p2_id_d    = p1_id_q;

      case (state_q)
         IDLE: begin
            if (bus.clr_start) begin
               state_d = CLEAR;
               cnt_d   = '0;
            end else if (!RESET) begin
               // last_q = 1 means requester 1 won last, so requester 0 wins a tie.
               if (bus.req0 && (!bus.req1 || last_q)) begin
                  gnt0 = 1'b1;
               end else if (bus.req1) begin
                  gnt1 = 1'b1;
               end
            end
            if (gnt0) begin
               last_d  = 1'b0;
               wen_d   = bus.we0;
               ren_d   = !bus.we0;
               addr_d  = bus.addr0;
               be_d    = bus.be0;
               wdata_d = bus.wdata0;
               rid_d   = 1'b0;
            end else if (gnt1) begin
               last_d  = 1'b1;
               wen_d   = bus.we1;
               ren_d   = !bus.we1;
               addr_d  = bus.addr1;
               be_d    = bus.be1;
               wdata_d = bus.wdata1;
               rid_d   = 1'b1;
            end
         end
         CLEAR: begin
            wen_d   = 1'b1;
            addr_d  = cnt_q;
            be_d    = 4'hF;
            wdata_d = '0;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST_WORD) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         last_q     <= 1'b1;
         wen_q      <= 1'b0;
         ren_q      <= 1'b0;
         be_q       <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rid_q      <= 1'b0;
         done_q     <= 1'b0;
         p1_valid_q <= 1'b0;
         p1_id_q    <= 1'b0;
         p2_valid_q <= 1'b0;
         p2_id_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         last_q     <= last_d;
         wen_q      <= wen_d;
         ren_q      <= ren_d;
         be_q       <= be_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rid_q      <= rid_d;
         done_q     <= done_d;
         p1_valid_q <= p1_valid_d;
         p1_id_q    <= p1_id_d;
         p2_valid_q <= p2_valid_d;
         p2_id_q    <= p2_id_d;
      end
   end

   assign bus.gnt0     = gnt0;
   assign bus.gnt1     = gnt1;
   assign bus.rvalid0  = p2_valid_q && !p2_id_q;
   assign bus.rvalid1  = p2_valid_q && p2_id_q;
   assign bus.rdata    = {ram_rparity, ram_rdata};
   assign bus.clr_busy = (state_q == CLEAR);
   assign bus.clr_done = done_q;

   assign ram_wen     = wen_q;
   assign ram_ren     = ren_q;
   assign ram_be      = be_q;
   assign ram_addr    = {addr_q, 5'b00000};
   assign ram_wdata   = wdata_q[31:0];
   assign ram_wparity = wdata_q[35:32];
endmodule

// File: tb/tb_tdp_ram36k_port_arbiter.sv
// Bench for tdp_ram36k_port_arbiter: port-A RAM model with two-cycle read
// latency, vector table for single-requester traffic, scoreboard for returns.
`timescale 1ns/1ps
module tb_tdp_ram36k_port_arbiter;
   localparam int DL = 10;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        ram_wen, ram_ren;
   logic [3:0]  ram_be;
   logic [14:0] ram_addr;
   logic [31:0] ram_wdata;
   logic [3:0]  ram_wparity;
   logic [31:0] ram_rdata;
   logic [3:0]  ram_rparity;

   always #5 CLK = ~CLK;

   tdp_ram36k_port_arbiter_if #(.DEPTH_LOG2(DL)) bus ();

   tdp_ram36k_port_arbiter #(.DEPTH_LOG2(DL)) dut (
      .CLK         (CLK),
      .RESET       (RESET),
      .bus         (bus),
      .ram_wen     (ram_wen),
      .ram_ren     (ram_ren),
      .ram_be      (ram_be),
      .ram_addr    (ram_addr),
      .ram_wdata   (ram_wdata),
      .ram_wparity (ram_wparity),
      .ram_rdata   (ram_rdata),
      .ram_rparity (ram_rparity)
   );

   // Port-A model: command sampled at the edge, registered output stage.
   logic [35:0] mem [0:1023];
   logic [35:0] rd1 = '0;
   logic [35:0] rdo = '0;
   always @(posedge CLK) begin
      if (ram_wen) begin
         for (int b = 0; b < 4; b++) begin
            if (ram_be[b]) begin
               mem[ram_addr[14:5]][8*b +: 8] <= ram_wdata[8*b +: 8];
               mem[ram_addr[14:5]][32+b]     <= ram_wparity[b];
            end
         end
      end
      if (ram_ren) rd1 <= mem[ram_addr[14:5]];
      rdo <= rd1;
   end
   assign ram_rdata   = rdo[31:0];
   assign ram_rparity = rdo[35:32];

   int n_cmp = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        id;
      logic [35:0] data;
   } exp_t;
   exp_t sbq[$];

   always @(negedge CLK) begin
      if (bus.rvalid0 || bus.rvalid1) begin
         check("rvalid_onehot", 64'(bus.rvalid0 & bus.rvalid1), 64'(0));
         if (sbq.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL rvalid_unexpected: got rvalid0=%0b rvalid1=%0b, expected none",
                     bus.rvalid0, bus.rvalid1);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            $display("read return id=%0d data=%h", bus.rvalid1, bus.rdata);
            check("rvalid_id", 64'(bus.rvalid1), 64'(e.id));
            check("rdata", 64'(bus.rdata), 64'(e.data));
         end
      end
   end

   function automatic logic [35:0] rrv(input int i);
      return {4'h3, 22'h155555, 10'(i)};
   endfunction

   function automatic logic [35:0] pat(input int i);
      return {4'h6, 22'h2AAAAA, 10'(i)};
   endfunction

   task automatic wait_gnt(input bit id);
      for (int c = 0; c < 50; c++) begin
         @(negedge CLK);
         if ((id == 1'b0 && bus.gnt0) || (id == 1'b1 && bus.gnt1)) return;
      end
      check("gnt_timeout", 64'(0), 64'(1));
   endtask

   // Presents one command, waits for its grant, returns #1 after the consuming edge.
   task automatic do_access(input bit id, input bit we, input logic [9:0] a,
                            input logic [35:0] wd, input logic [3:0] be,
                            input logic [35:0] exp);
      if (id == 1'b0) begin
         bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = a; bus.wdata0 = wd; bus.be0 = be;
      end else begin
         bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = a; bus.wdata1 = wd; bus.be1 = be;
      end
      wait_gnt(id);
      if (!we) sbq.push_back('{id: id, data: exp});
      $display("req%0d %s addr=%0d wdata=%h be=%h", id, we ? "write" : "read", a, wd, be);
      @(posedge CLK);
      #1;
      if (id == 1'b0) bus.req0 = 1'b0;
      else bus.req1 = 1'b0;
   endtask

   typedef struct {
      logic        we;
      logic [9:0]  addr;
      logic [35:0] wdata;
      logic [3:0]  be;
      logic [35:0] exp;
   } vec_t;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vt[5];
      int   n0, n1, g, nwr, addr_err, gnt_seen, done_seen, busy_seen;
      bit   done_hit;

      vt[0] = '{we: 1'b1, addr: 10'd5, wdata: 36'h9_DEADBEEF, be: 4'hF, exp: 36'h0};
      vt[1] = '{we: 1'b0, addr: 10'd5, wdata: 36'h0,          be: 4'hF, exp: 36'h9_DEADBEEF};
      vt[2] = '{we: 1'b1, addr: 10'd7, wdata: 36'hF_FFFFFFFF, be: 4'hF, exp: 36'h0};
      vt[3] = '{we: 1'b1, addr: 10'd7, wdata: 36'h0,          be: 4'b0101, exp: 36'h0};
      vt[4] = '{we: 1'b0, addr: 10'd7, wdata: 36'h0,          be: 4'hF, exp: 36'hA_FF00FF00};

      for (int i = 0; i < 1024; i++) mem[i] = '0;
      for (int i = 20; i < 26; i++) mem[i] = rrv(i);

      bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = '0; bus.wdata0 = '0; bus.be0 = '0;
      bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0; bus.be1 = '0;
      bus.clr_start = 1'b0;

      // Reset with a pending request.
      @(posedge CLK);
      #1;
      check("rst_gnt0", 64'(bus.gnt0), 64'(0));
      check("rst_wen", 64'(ram_wen), 64'(0));
      check("rst_ren", 64'(ram_ren), 64'(0));
      check("rst_be", 64'(ram_be), 64'(0));
      check("rst_addr", 64'(ram_addr), 64'(0));
      check("rst_wdata", 64'(ram_wdata), 64'(0));
      check("rst_wparity", 64'(ram_wparity), 64'(0));
      check("rst_busy", 64'(bus.clr_busy), 64'(0));
      check("rst_done", 64'(bus.clr_done), 64'(0));
      check("rst_rvalid", 64'({bus.rvalid0, bus.rvalid1}), 64'(0));
      @(posedge CLK);
      #1;
      check("rst_gnt0_2", 64'(bus.gnt0), 64'(0));
      RESET = 1'b0;
      bus.req0 = 1'b0;
      @(posedge CLK);
      #1;

      // Round-robin: both requesters hold reads; requester 0 wins the first tie.
      n0 = 0; n1 = 0;
      bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 10'd20;
      bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 10'd21;
      for (int c = 0; c < 6; c++) begin
         @(negedge CLK);
         g = bus.gnt1 ? 1 : 0;
         check("rr_onehot", 64'(bus.gnt0 + bus.gnt1), 64'(1));
         check("rr_order", 64'(bus.gnt1), 64'(c % 2));
         sbq.push_back('{id: g[0], data: g == 1 ? rrv(21 + 2*n1) : rrv(20 + 2*n0)});
         $display("rr grant %0d -> requester %0d", c, g);
         @(posedge CLK);
         #1;
         if (g == 0) begin
            n0++;
            bus.addr0 = 10'(20 + 2*n0);
            if (n0 == 3) bus.req0 = 1'b0;
         end else begin
            n1++;
            bus.addr1 = 10'(21 + 2*n1);
            if (n1 == 3) bus.req1 = 1'b0;
         end
      end
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      repeat (4) @(posedge CLK);
      #1;

      // Vector table: back-to-back single-requester commands.
      for (int i = 0; i < 5; i++) begin
         do_access(1'b0, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].be, vt[i].exp);
         check("cmd_wen", 64'(ram_wen), 64'(vt[i].we));
         check("cmd_ren", 64'(ram_ren), 64'(!vt[i].we));
         check("cmd_addr", 64'(ram_addr), 64'({vt[i].addr, 5'b00000}));
         if (vt[i].we) begin
            check("cmd_wdata", 64'({ram_wparity, ram_wdata}), 64'(vt[i].wdata));
            check("cmd_be", 64'(ram_be), 64'(vt[i].be));
         end
      end
      repeat (5) @(posedge CLK);
      #1;

      // Reset flushes an in-flight read.
      bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 10'd5;
      wait_gnt(1'b0);
      @(posedge CLK);
      #1;
      bus.req0 = 1'b0;
      RESET = 1'b1;
      @(posedge CLK);
      #1;
      RESET = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge CLK);
         check("flush_rvalid", 64'({bus.rvalid0, bus.rvalid1}), 64'(0));
      end
      @(posedge CLK);
      #1;

      // Full clear with requester 1 waiting; its read lands in the clr_done cycle.
      bus.clr_start = 1'b1;
      bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 10'd5;
      @(negedge CLK);
      check("clr_start_prio", 64'({bus.gnt0, bus.gnt1}), 64'(0));
      @(posedge CLK);
      #1;
      bus.clr_start = 1'b0;
      nwr = 0; addr_err = 0; gnt_seen = 0; busy_seen = 0; done_hit = 1'b0;
      for (int c = 0; c < 1100; c++) begin
         @(negedge CLK);
         if (ram_wen) begin
            if (ram_addr != {10'(nwr), 5'b00000} || ram_be != 4'hF ||
                ram_wdata != 32'h0 || ram_wparity != 4'h0) addr_err++;
            nwr++;
         end
         if (bus.clr_done) begin
            done_hit = 1'b1;
            check("clr_done_gnt1", 64'(bus.gnt1), 64'(1));
            check("clr_done_busy", 64'(bus.clr_busy), 64'(0));
            if (bus.gnt1) sbq.push_back('{id: 1'b1, data: 36'h0});
            break;
         end
         if (bus.gnt1 || bus.gnt0) gnt_seen++;
         if (bus.clr_busy) busy_seen++;
      end
      check("clr_done_seen", 64'(done_hit), 64'(1));
      check("clr_write_count", 64'(nwr), 64'(1024));
      check("clr_addr_seq", 64'(addr_err), 64'(0));
      check("clr_no_gnt", 64'(gnt_seen), 64'(0));
      check("clr_busy_cycles", 64'(busy_seen), 64'(1024));
      @(posedge CLK);
      #1;
      bus.req1 = 1'b0;
      do_access(1'b0, 1'b0, 10'd21, 36'h0, 4'hF, 36'h0);
      do_access(1'b1, 1'b0, 10'd1023, 36'h0, 4'hF, 36'h0);
      repeat (4) @(posedge CLK);
      #1;

      // Reset mid-clear: sweep stops after word 299.
      for (int i = 0; i < 1024; i++) mem[i] = pat(i);
      bus.clr_start = 1'b1;
      @(posedge CLK);
      #1;
      bus.clr_start = 1'b0;
      done_hit = 1'b0;
      for (int c = 0; c < 1100; c++) begin
         @(negedge CLK);
         if (ram_wen && ram_addr[14:5] == 10'd299) begin
            done_hit = 1'b1;
            break;
         end
      end
      check("midclr_reached_299", 64'(done_hit), 64'(1));
      RESET = 1'b1;
      @(posedge CLK);
      #1;
      RESET = 1'b0;
      check("midclr_wen", 64'(ram_wen), 64'(0));
      check("midclr_busy", 64'(bus.clr_busy), 64'(0));
      done_seen = 0;
      busy_seen = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge CLK);
         if (bus.clr_done) done_seen++;
         if (bus.clr_busy) busy_seen++;
      end
      check("midclr_no_done", 64'(done_seen), 64'(0));
      check("midclr_no_busy", 64'(busy_seen), 64'(0));
      @(posedge CLK);
      #1;
      do_access(1'b0, 1'b0, 10'd0, 36'h0, 4'hF, 36'h0);
      do_access(1'b0, 1'b0, 10'd299, 36'h0, 4'hF, 36'h0);
      do_access(1'b0, 1'b0, 10'd300, 36'h0, 4'hF, pat(300));
      do_access(1'b1, 1'b0, 10'd1023, 36'h0, 4'hF, pat(1023));

      repeat (8) @(posedge CLK);
      #1;
      check("scoreboard_empty", 64'(sbq.size()), 64'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
